// File: rtl/sdram_tg_pkg.sv
// Shared types for the SDRAM traffic generator: FSM states,
// pattern codes, Galois LFSR tap table and error counter limit.
package sdram_tg_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_INIT,
      S_WR_BURST,
      S_WR_GAP,
      S_RD_BURST,
      S_RD_GAP,
      S_DONE
   } tg_state_t;

   localparam logic [1:0] PAT_INCR  = 2'd0;
   localparam logic [1:0] PAT_LFSR  = 2'd1;
   localparam logic [1:0] PAT_WALK  = 2'd2;
   localparam logic [1:0] PAT_CONST = 2'd3;

   localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

   // Right-shifting Galois masks for maximal-length polynomials
   function automatic logic [31:0] lfsr_taps(input int w);
      logic [31:0] t;
      case (w)
         4:       t = 32'h0000_000C;
         8:       t = 32'h0000_00B8;
         16:      t = 32'h0000_B400;
         24:      t = 32'h00E1_0000;
         32:      t = 32'h8020_0003;
         default: t = 32'h0000_B400;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/sdram_tg_pattern.sv
// Pattern word generator P(k,i); the LFSR state advances one step
// per accepted word and is reloaded from the seed on reseed.
module sdram_tg_pattern
   import sdram_tg_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 24,
   parameter int LEN_W     = 10,
   parameter int KW        = 2,
   parameter int BURST_LEN = 256
)(
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic [KW-1:0]     i_k,
   input  logic [LEN_W-1:0]  i_i,
   input  logic              i_step,
   input  logic              i_reseed,
   input  logic [1:0]        i_sel,
   input  logic [DATA_W-1:0] i_seed,
   output logic [DATA_W-1:0] o_word
);

   localparam int NW = ADDR_W + LEN_W;
   localparam logic [DATA_W-1:0] TAPS =
      DATA_W'(lfsr_taps(DATA_W));

   logic [NW-1:0]     w_n;
   logic [DATA_W-1:0] r_lfsr;

   assign w_n = NW'(i_k) * NW'(BURST_LEN) + NW'(i_i);

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n)
         r_lfsr <= DATA_W'(1);
      else if (i_reseed)
         r_lfsr <= (i_seed == '0) ? DATA_W'(1) : i_seed;
      else if (i_step)
         r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
   end

   always_comb begin
      o_word = '0;
      unique case (1'b1)
         (i_sel == PAT_INCR):  o_word = w_n[DATA_W-1:0];
         (i_sel == PAT_LFSR):  o_word = r_lfsr;
         (i_sel == PAT_WALK):  o_word = DATA_W'(1) << (w_n % NW'(DATA_W));
         (i_sel == PAT_CONST): o_word = i_seed;
         default:              o_word = '0;
      endcase
   end

endmodule

// File: rtl/sdram_traffic_gen.sv
// SDRAM write/read-back traffic generator and checker for sdram_ctrl.
// Define SDRAM_TG_ERR_LOG_EN to add first-mismatch capture outputs.
module sdram_traffic_gen
   import sdram_tg_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 24,
   parameter int LEN_W      = 10,
   parameter int BURST_LEN  = 256,
   parameter int NUM_BURSTS = 4,
   parameter int ADDR_STEP  = 256,
   parameter int TIMEOUT    = 4096
)(
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        pattern_sel,
   input  logic [DATA_W-1:0] seed,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              init_end,
   output logic              sdram_wr_req,
   output logic [ADDR_W-1:0] sdram_wr_addr,
   output logic [LEN_W-1:0]  wr_burst_len,
   output logic [DATA_W-1:0] sdram_data_in,
   input  logic              sdram_wr_ack,
   output logic              sdram_rd_req,
   output logic [ADDR_W-1:0] sdram_rd_addr,
   output logic [LEN_W-1:0]  rd_burst_len,
   input  logic [DATA_W-1:0] sdram_data_out,
   input  logic              sdram_rd_ack,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              timeout,
   output logic [15:0]       err_cnt
`ifdef SDRAM_TG_ERR_LOG_EN
   ,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [DATA_W-1:0] first_err_exp,
   output logic [DATA_W-1:0] first_err_act
`endif
);

   localparam int KW = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [KW-1:0]     K_LAST = KW'(NUM_BURSTS - 1);
   localparam logic [LEN_W-1:0]  I_LAST = LEN_W'(BURST_LEN - 1);
   localparam logic [TW-1:0]     T_LAST = TW'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(ADDR_STEP);

   tg_state_t         r_state;
   tg_state_t         w_next;
   logic [KW-1:0]     r_k;
   logic [LEN_W-1:0]  r_i;
   logic [TW-1:0]     r_tmo;
   logic [ADDR_W-1:0] r_base;
   logic [1:0]        r_sel;
   logic [DATA_W-1:0] r_seed;
   logic              r_done;
   logic              r_error;
   logic              r_timeout;
   logic [15:0]       r_err_cnt;

   logic              w_start;
   logic              w_in_burst;
   logic              w_wr_ack;
   logic              w_rd_ack;
   logic              w_ack;
   logic              w_tmo_hit;
   logic              w_mis;
   logic              w_reseed;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wr_word;
   logic [DATA_W-1:0] w_exp;

   assign w_start    = start && (r_state == S_IDLE);
   assign w_in_burst = (r_state == S_WR_BURST) ||
                       (r_state == S_RD_BURST);
   assign w_wr_ack   = sdram_wr_ack && (r_state == S_WR_BURST);
   assign w_rd_ack   = sdram_rd_ack && (r_state == S_RD_BURST);
   assign w_ack      = w_wr_ack || w_rd_ack;
   assign w_tmo_hit  = w_in_burst && !w_ack && (r_tmo == T_LAST);
   assign w_mis      = w_rd_ack && (sdram_data_out != w_exp);
   assign w_reseed   = (r_state == S_WAIT_INIT);
   assign w_addr     = r_base + ADDR_W'(r_k) * STEP;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:
            if (start) w_next = S_WAIT_INIT;
         S_WAIT_INIT:
            if (init_end) w_next = S_WR_BURST;
         S_WR_BURST:
            if (w_tmo_hit)
               w_next = S_DONE;
            else if (w_wr_ack && r_i == I_LAST)
               w_next = S_WR_GAP;
         S_WR_GAP:
            w_next = (r_k == K_LAST) ? S_RD_BURST : S_WR_BURST;
         S_RD_BURST:
            if (w_tmo_hit)
               w_next = S_DONE;
            else if (w_rd_ack && r_i == I_LAST)
               w_next = S_RD_GAP;
         S_RD_GAP:
            w_next = (r_k == K_LAST) ? S_DONE : S_RD_BURST;
         S_DONE:
            w_next = S_IDLE;
         default:
            w_next = S_IDLE;
      endcase
   end

   always_comb begin
      sdram_wr_req = 1'b0;
      sdram_rd_req = 1'b0;
      busy         = 1'b1;
      unique case (r_state)
         S_IDLE,
         S_DONE:     busy = 1'b0;
         S_WR_BURST: sdram_wr_req = 1'b1;
         S_RD_BURST: sdram_rd_req = 1'b1;
         default:    busy = 1'b1;
      endcase
   end

   // Burst/word indices are shared by the write and read phases
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k    <= '0;
         r_i    <= '0;
         r_base <= '0;
         r_sel  <= PAT_INCR;
         r_seed <= '0;
      end else if (w_start) begin
         r_k    <= '0;
         r_i    <= '0;
         r_base <= base_addr;
         r_sel  <= pattern_sel;
         r_seed <= seed;
      end else begin
         if (w_ack)
            r_i <= (r_i == I_LAST) ? '0 : r_i + 1'b1;
         if (r_state == S_WR_GAP || r_state == S_RD_GAP)
            r_k <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n)
         r_tmo <= '0;
      else if (!w_in_burst || w_ack)
         r_tmo <= '0;
      else
         r_tmo <= r_tmo + 1'b1;
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done    <= 1'b0;
         r_error   <= 1'b0;
         r_timeout <= 1'b0;
         r_err_cnt <= '0;
      end else if (w_start) begin
         r_done    <= 1'b0;
         r_error   <= 1'b0;
         r_timeout <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         if (w_next == S_DONE)
            r_done <= 1'b1;
         if (w_tmo_hit) begin
            r_timeout <= 1'b1;
            r_error   <= 1'b1;
         end
         if (w_mis) begin
            r_error <= 1'b1;
            if (r_err_cnt != ERR_CNT_MAX)
               r_err_cnt <= r_err_cnt + 1'b1;
         end
      end
   end

   sdram_tg_pattern #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .LEN_W     (LEN_W),
      .KW        (KW),
      .BURST_LEN (BURST_LEN)
   ) u_wr_pat (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .i_k      (r_k),
      .i_i      (r_i),
      .i_step   (w_wr_ack),
      .i_reseed (w_reseed),
      .i_sel    (r_sel),
      .i_seed   (r_seed),
      .o_word   (w_wr_word)
   );

   // Independent copy replays the same sequence during read-back
   sdram_tg_pattern #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .LEN_W     (LEN_W),
      .KW        (KW),
      .BURST_LEN (BURST_LEN)
   ) u_exp_pat (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .i_k      (r_k),
      .i_i      (r_i),
      .i_step   (w_rd_ack),
      .i_reseed (w_reseed),
      .i_sel    (r_sel),
      .i_seed   (r_seed),
      .o_word   (w_exp)
   );

   assign sdram_wr_addr = w_addr;
   assign sdram_rd_addr = w_addr;
   assign sdram_data_in = w_wr_word;
   assign wr_burst_len  = LEN_W'(BURST_LEN);
   assign rd_burst_len  = LEN_W'(BURST_LEN);
   assign done          = r_done;
   assign error         = r_error;
   assign timeout       = r_timeout;
   assign err_cnt       = r_err_cnt;

`ifdef SDRAM_TG_ERR_LOG_EN
   logic [ADDR_W-1:0] r_fe_addr;
   logic [DATA_W-1:0] r_fe_exp;
   logic [DATA_W-1:0] r_fe_act;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fe_addr <= '0;
         r_fe_exp  <= '0;
         r_fe_act  <= '0;
      end else if (w_start) begin
         r_fe_addr <= '0;
         r_fe_exp  <= '0;
         r_fe_act  <= '0;
      end else if (w_mis && r_err_cnt == '0) begin
         r_fe_addr <= w_addr + ADDR_W'(r_i);
         r_fe_exp  <= w_exp;
         r_fe_act  <= sdram_data_out;
      end
   end

   assign first_err_addr = r_fe_addr;
   assign first_err_exp  = r_fe_exp;
   assign first_err_act  = r_fe_act;
`endif

endmodule

// File: tb/tb_sdram_traffic_gen.sv
// Directed bench for sdram_traffic_gen: table of full passes against
// a memory model, plus init-wait, timeout and reset-mid-read cases.
module tb_sdram_traffic_gen;

   localparam int DW   = 16;
   localparam int AW   = 24;
   localparam int LW   = 10;
   localparam int BL   = 256;
   localparam int NB   = 4;
   localparam int STEP = 256;
   localparam int TMO  = 4096;

   logic          sys_clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    pattern_sel = 2'd0;
   logic [DW-1:0] seed = '0;
   logic [AW-1:0] base_addr = '0;
   logic          init_end = 1'b0;
   logic          sdram_wr_req;
   logic [AW-1:0] sdram_wr_addr;
   logic [LW-1:0] wr_burst_len;
   logic [DW-1:0] sdram_data_in;
   logic          sdram_wr_ack = 1'b0;
   logic          sdram_rd_req;
   logic [AW-1:0] sdram_rd_addr;
   logic [LW-1:0] rd_burst_len;
   logic [DW-1:0] sdram_data_out = '0;
   logic          sdram_rd_ack = 1'b0;
   logic          busy;
   logic          done;
   logic          error;
   logic          timeout;
   logic [15:0]   err_cnt;
`ifdef SDRAM_TG_ERR_LOG_EN
   logic [AW-1:0] first_err_addr;
   logic [DW-1:0] first_err_exp;
   logic [DW-1:0] first_err_act;
`endif

   sdram_traffic_gen #(
      .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .BURST_LEN(BL),
      .NUM_BURSTS(NB), .ADDR_STEP(STEP), .TIMEOUT(TMO)
   ) dut (
      .sys_clk        (sys_clk),
      .rst_n          (rst_n),
      .start          (start),
      .pattern_sel    (pattern_sel),
      .seed           (seed),
      .base_addr      (base_addr),
      .init_end       (init_end),
      .sdram_wr_req   (sdram_wr_req),
      .sdram_wr_addr  (sdram_wr_addr),
      .wr_burst_len   (wr_burst_len),
      .sdram_data_in  (sdram_data_in),
      .sdram_wr_ack   (sdram_wr_ack),
      .sdram_rd_req   (sdram_rd_req),
      .sdram_rd_addr  (sdram_rd_addr),
      .rd_burst_len   (rd_burst_len),
      .sdram_data_out (sdram_data_out),
      .sdram_rd_ack   (sdram_rd_ack),
      .busy           (busy),
      .done           (done),
      .error          (error),
      .timeout        (timeout),
      .err_cnt        (err_cnt)
`ifdef SDRAM_TG_ERR_LOG_EN
      ,
      .first_err_addr (first_err_addr),
      .first_err_exp  (first_err_exp),
      .first_err_act  (first_err_act)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   // ---------------- memory / controller model ----------------
   logic [15:0] mem [logic [23:0]];
   logic [23:0] wbaddr [$];
   logic [23:0] rbaddr [$];
   int  wcnt, rcnt, wr_total, wr_bursts, rd_bursts, stall, cyc;
   bit  prev_w, prev_r, last_clr;
   bit  clr = 1'b0;
   bit  gap_mode = 1'b0;
   bit  corrupt = 1'b0;
   int  stall_after = -1;
   bit  m_ok;
   logic [23:0] ma;
   logic [15:0] md;

   always @(negedge sys_clk) begin
      sdram_wr_ack   = 1'b0;
      sdram_rd_ack   = 1'b0;
      sdram_data_out = 16'h0;
      cyc++;
      if (clr != last_clr) begin
         last_clr = clr;
         mem.delete();
         wbaddr.delete();
         rbaddr.delete();
         wr_total  = 0;
         wr_bursts = 0;
         rd_bursts = 0;
         stall     = 0;
      end
      m_ok = !(gap_mode && (cyc % 3 == 0)) &&
             !(stall_after >= 0 && wr_total >= stall_after);
      if (!rst_n) begin
         prev_w = 1'b0;
         prev_r = 1'b0;
      end else begin
         if (sdram_wr_req) begin
            if (!prev_w) begin
               wcnt = 0;
               wr_bursts++;
               wbaddr.push_back(sdram_wr_addr);
            end
            if (m_ok) begin
               sdram_wr_ack = 1'b1;
               ma = sdram_wr_addr + 24'(wcnt);
               mem[ma] = sdram_data_in;
               wcnt++;
               wr_total++;
            end else begin
               stall++;
            end
         end
         if (sdram_rd_req) begin
            if (!prev_r) begin
               rcnt = 0;
               rd_bursts++;
               rbaddr.push_back(sdram_rd_addr);
            end
            if (m_ok) begin
               ma = sdram_rd_addr + 24'(rcnt);
               md = mem.exists(ma) ? mem[ma] : 16'h0;
               if (corrupt && rd_bursts == 3 && rcnt == 10)
                  md = 16'hDEAD;
               sdram_rd_ack   = 1'b1;
               sdram_data_out = md;
               rcnt++;
            end
         end
         prev_w = sdram_wr_req;
         prev_r = sdram_rd_req;
      end
   end

   // ---------------- checking ----------------
   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   logic [15:0] expv [NB*BL];

   task automatic build_exp(input logic [1:0] sel, input logic [15:0] sd);
      logic [15:0] s;
      s = (sd == 16'h0) ? 16'h1 : sd;
      for (int n = 0; n < NB*BL; n++) begin
         case (sel)
            2'd0: expv[n] = 16'(n);
            2'd1: begin
               expv[n] = s;
               s = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0);
            end
            2'd2: expv[n] = 16'h1 << (n % 16);
            default: expv[n] = sd;
         endcase
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, output bit ok);
      int n;
      n = 0;
      while (!done && n < bound) begin
         @(negedge sys_clk);
         n++;
      end
      ok = done;
   endtask

   typedef struct {
      logic [1:0]  sel;
      logic [15:0] seed;
      logic [23:0] base;
      bit          gap;
      bit          corrupt;
      logic [15:0] exp_err;
      logic [23:0] exp_b1;
      logic [15:0] exp_w1;
      logic [23:0] exp_fa;
   } vec_t;

   vec_t        tbl [7];
   bit          ok;
   int          wbad;
   int          reqseen;
   logic [23:0] a;

   initial begin
      tbl[0] = '{2'd0, 16'h0000, 24'h000000, 1'b0, 1'b0,
                 16'd0, 24'h000100, 16'h0001, 24'h0};
      tbl[1] = '{2'd1, 16'hACE1, 24'h000000, 1'b0, 1'b0,
                 16'd0, 24'h000100, 16'hE270, 24'h0};
      tbl[2] = '{2'd1, 16'h0000, 24'h000000, 1'b0, 1'b0,
                 16'd0, 24'h000100, 16'hB400, 24'h0};
      tbl[3] = '{2'd2, 16'h0000, 24'h001000, 1'b1, 1'b0,
                 16'd0, 24'h001100, 16'h0002, 24'h0};
      tbl[4] = '{2'd3, 16'h5A5A, 24'h000000, 1'b0, 1'b1,
                 16'd1, 24'h000100, 16'h5A5A, 24'h00020A};
      tbl[5] = '{2'd0, 16'h0000, 24'hFFFF00, 1'b0, 1'b0,
                 16'd0, 24'h000000, 16'h0001, 24'h0};
      tbl[6] = '{2'd0, 16'h0000, 24'h000000, 1'b1, 1'b1,
                 16'd1, 24'h000100, 16'h0001, 24'h00020A};

      repeat (3) @(negedge sys_clk);
      chk("rst_ctrl", 64'({sdram_wr_req, sdram_rd_req, busy, done,
                           error, timeout}), 64'd0);
      chk("rst_errcnt", 64'(err_cnt), 64'd0);
      chk("rst_addr", 64'({sdram_wr_addr, sdram_rd_addr}), 64'd0);
      chk("rst_data", 64'(sdram_data_in), 64'd0);
      chk("rst_len", 64'({wr_burst_len, rd_burst_len}),
          64'({10'd256, 10'd256}));

      rst_n    = 1'b1;
      init_end = 1'b1;
      @(negedge sys_clk);

      for (int v = 0; v < 7; v++) begin
         pattern_sel = tbl[v].sel;
         seed        = tbl[v].seed;
         base_addr   = tbl[v].base;
         gap_mode    = tbl[v].gap;
         corrupt     = tbl[v].corrupt;
         build_exp(tbl[v].sel, tbl[v].seed);
         clr = ~clr;
         @(negedge sys_clk);
         pulse_start();
         wait_done(20000, ok);
         chk($sformatf("v%0d_done", v), 64'(ok), 64'd1);
         @(negedge sys_clk);
         chk($sformatf("v%0d_busy", v), 64'(busy), 64'd0);
         chk($sformatf("v%0d_error", v), 64'(error),
             64'(tbl[v].exp_err != 16'd0));
         chk($sformatf("v%0d_tmo", v), 64'(timeout), 64'd0);
         chk($sformatf("v%0d_errcnt", v), 64'(err_cnt),
             64'(tbl[v].exp_err));
         chk($sformatf("v%0d_bursts", v), 64'({wr_bursts, rd_bursts}),
             {32'(NB), 32'(NB)});
         chk($sformatf("v%0d_wb1", v), 64'(wbaddr[1]),
             64'(tbl[v].exp_b1));
         chk($sformatf("v%0d_rb1", v), 64'(rbaddr[1]),
             64'(tbl[v].exp_b1));
         a = tbl[v].base + 24'd1;
         chk($sformatf("v%0d_word1", v),
             64'(mem.exists(a) ? mem[a] : 16'hxxxx), 64'(tbl[v].exp_w1));
         wbad = 0;
         for (int k = 0; k < NB; k++)
            for (int i = 0; i < BL; i++) begin
               a = tbl[v].base + 24'(k*STEP + i);
               if (!mem.exists(a) || mem[a] !== expv[k*BL+i])
                  wbad++;
            end
         chk($sformatf("v%0d_wdata", v), 64'(wbad), 64'd0);
`ifdef SDRAM_TG_ERR_LOG_EN
         chk($sformatf("v%0d_fe_addr", v), 64'(first_err_addr),
             64'(tbl[v].exp_fa));
         if (tbl[v].corrupt)
            chk($sformatf("v%0d_fe_act", v), 64'(first_err_act),
                64'h0000_DEAD);
`endif
      end
      gap_mode = 1'b0;
      corrupt  = 1'b0;

      // init_end held low: no request may appear
      init_end    = 1'b0;
      pattern_sel = 2'd0;
      base_addr   = 24'h0;
      clr = ~clr;
      @(negedge sys_clk);
      pulse_start();
      reqseen = 0;
      for (int c = 0; c < 500; c++) begin
         if (sdram_wr_req || sdram_rd_req)
            reqseen++;
         @(negedge sys_clk);
      end
      chk("init_noreq", 64'(reqseen), 64'd0);
      chk("init_busy", 64'(busy), 64'd1);
      init_end = 1'b1;
      wait_done(20000, ok);
      chk("init_done", 64'(ok), 64'd1);
      chk("init_err", 64'({error, err_cnt}), 64'd0);
      chk("init_bursts", 64'({wr_bursts, rd_bursts}),
          {32'(NB), 32'(NB)});

      // controller stops acking mid-write; a second start is ignored
      stall_after = 100;
      clr = ~clr;
      @(negedge sys_clk);
      pulse_start();
      repeat (50) @(negedge sys_clk);
      pulse_start();
      chk("mid_start_busy", 64'(busy), 64'd1);
      wait_done(10000, ok);
      chk("tmo_done", 64'(ok), 64'd1);
      chk("tmo_flags", 64'({sdram_wr_req, busy, timeout, error}),
          64'b0011);
      chk("tmo_cycles", 64'(stall), 64'(TMO));
      chk("tmo_words", 64'(wr_total), 64'd100);
      chk("tmo_bursts", 64'({wr_bursts, rd_bursts}), {32'd1, 32'd0});
      chk("tmo_errcnt", 64'(err_cnt), 64'd0);
      stall_after = -1;

      // asynchronous reset during a read burst
      pattern_sel = 2'd2;
      base_addr   = 24'h001000;
      clr = ~clr;
      @(negedge sys_clk);
      pulse_start();
      reqseen = 0;
      while (!(sdram_rd_req && rcnt > 20) && reqseen < 5000) begin
         @(negedge sys_clk);
         reqseen++;
      end
      chk("rd_reached", 64'(sdram_rd_req), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_ctrl", 64'({sdram_wr_req, sdram_rd_req, busy, done,
                               error, timeout}), 64'd0);
      chk("rst_mid_addr", 64'({sdram_wr_addr, sdram_rd_addr}), 64'd0);
      chk("rst_mid_data", 64'({sdram_data_in, err_cnt}), 64'd0);
      @(negedge sys_clk);
      rst_n = 1'b1;
      @(negedge sys_clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
